// File: rtl/a2d_intf.sv
// a2d_intf: round-robin SPI master for an 8-channel 12-bit ADC.
// Each conversion sends a command frame, then a read frame carrying the same command.
module a2d_intf #(
   parameter int unsigned PERIOD_W = 14
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MISO,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   output logic [11:0] batt,
   output logic [11:0] curr,
   output logic [11:0] brake,
   output logic [11:0] torque,
   output logic        cnv_cmplt
);

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StGap,
      StRead,
      StDone
   } state_e;

   // Loading 5'b10111 keeps SCLK high for 8 clks after SS_n falls; the divider
   // is parked at this value between frames so SCLK idles high.
   localparam logic [4:0] SclkLoad    = 5'b10111;
   localparam logic [4:0] SclkPreRise = 5'b01111;
   localparam logic [4:0] SclkPreFall = 5'b11111;

   state_e              state_q;
   logic [PERIOD_W-1:0] timer_q;
   logic [1:0]          robin_q;
   logic                gap_q;
   logic [11:0]         batt_q;
   logic [11:0]         curr_q;
   logic [11:0]         brake_q;
   logic [11:0]         torque_q;
   logic                cnv_cmplt_q;

   logic                ss_n_q;
   logic [4:0]          sclk_div_q;
   logic [15:0]         shft_q;
   logic                sample_q;
   logic                sampled_q;
   logic [3:0]          bit_cnt_q;
   logic                last_q;

   logic                timer_full;
   logic                start_txn;
   logic                spi_busy;
   logic [2:0]          chnl;
   logic [15:0]         cmd_word;

   always_ff @(posedge clk) begin : timer_ff
      if (!rst_n) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_q + PERIOD_W'(1);
      end
   end

   always_comb begin
      chnl = 3'd0;
      case (robin_q)
         2'd0:    chnl = 3'd0;
         2'd1:    chnl = 3'd1;
         2'd2:    chnl = 3'd3;
         default: chnl = 3'd4;
      endcase
   end

   assign cmd_word   = {2'b00, chnl, 11'h000};
   assign timer_full = &timer_q;
   assign start_txn  = ((state_q == StIdle) && timer_full) || ((state_q == StGap) && gap_q);
   assign spi_busy   = ((state_q == StCmd) || (state_q == StRead)) && !last_q;

   // Shared SPI frame engine for both the command and the read frame.
   always_ff @(posedge clk) begin : spi_ff
      if (!rst_n) begin
         ss_n_q     <= 1'b1;
         sclk_div_q <= SclkLoad;
         shft_q     <= '0;
         sample_q   <= 1'b0;
         sampled_q  <= 1'b0;
         bit_cnt_q  <= '0;
         last_q     <= 1'b0;
      end else if (start_txn) begin
         ss_n_q     <= 1'b0;
         sclk_div_q <= SclkLoad;
         shft_q     <= cmd_word;
         sampled_q  <= 1'b0;
         bit_cnt_q  <= '0;
         last_q     <= 1'b0;
      end else if (spi_busy) begin
         sclk_div_q <= sclk_div_q + 5'd1;
         if (sclk_div_q == SclkPreRise) begin
            sample_q  <= MISO;
            sampled_q <= 1'b1;
         end
         // The first falling edge arrives before any sample and must not shift.
         if ((sclk_div_q == SclkPreFall) && sampled_q) begin
            shft_q    <= {shft_q[14:0], sample_q};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
               last_q     <= 1'b1;
               sclk_div_q <= SclkLoad;
            end
         end
      end else if (last_q) begin
         ss_n_q <= 1'b1;
         last_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin : fsm_ff
      if (!rst_n) begin
         state_q     <= StIdle;
         robin_q     <= '0;
         gap_q       <= 1'b0;
         batt_q      <= '0;
         curr_q      <= '0;
         brake_q     <= '0;
         torque_q    <= '0;
         cnv_cmplt_q <= 1'b0;
      end else begin
         cnv_cmplt_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (timer_full) state_q <= StCmd;
            end
            StCmd: begin
               if (last_q) begin
                  state_q <= StGap;
                  gap_q   <= 1'b0;
               end
            end
            StGap: begin
               if (gap_q) state_q <= StRead;
               else       gap_q   <= 1'b1;
            end
            StRead: begin
               if (last_q) begin
                  state_q     <= StDone;
                  cnv_cmplt_q <= 1'b1;
                  robin_q     <= robin_q + 2'd1;
                  case (robin_q)
                     2'd0:    batt_q   <= shft_q[11:0];
                     2'd1:    curr_q   <= shft_q[11:0];
                     2'd2:    brake_q  <= shft_q[11:0];
                     default: torque_q <= shft_q[11:0];
                  endcase
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign SS_n      = ss_n_q;
   assign SCLK      = sclk_div_q[4];
   assign MOSI      = ~ss_n_q & shft_q[15];
   assign batt      = batt_q;
   assign curr      = curr_q;
   assign brake     = brake_q;
   assign torque    = torque_q;
   assign cnv_cmplt = cnv_cmplt_q;

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: ADC slave model, frame monitor, table-driven and random conversions.
module tb_a2d_intf;

   localparam int unsigned PW = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        MISO = 1'b0;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic [11:0] batt;
   logic [11:0] curr;
   logic [11:0] brake;
   logic [11:0] torque;
   logic        cnv_cmplt;

   a2d_intf #(.PERIOD_W(PW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .MISO      (MISO),
      .SS_n      (SS_n),
      .SCLK      (SCLK),
      .MOSI      (MOSI),
      .batt      (batt),
      .curr      (curr),
      .brake     (brake),
      .torque    (torque),
      .cnv_cmplt (cnv_cmplt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp_v, $time);
      end
   endtask

   // ADC contents, indexed by 3-bit channel number.
   logic [15:0] adc_word [8];

   int cyc = 0;
   int rst_cyc = 0;
   bit rst_seen = 1'b0;

   always @(posedge clk) begin
      cyc++;
      rst_seen = rst_n;
      if (!rst_n) rst_cyc = cyc;
   end

   // Frame monitor and ADC slave; runs on the falling clock edge.
   bit          ss_prev = 1'b1;
   bit          sclk_prev = 1'b1;
   bit          cnv_prev = 1'b0;
   bit          in_win = 1'b0;
   int          win_idx = 0;
   int          rises = 0;
   int          gap_cnt = 0;
   logic [15:0] mosi_word = '0;
   logic [15:0] tx = '0;
   logic [15:0] last_cmd = '0;
   int          cmd_start_cyc = 0;
   int          done_cyc = 0;
   bit          have_done = 1'b0;
   logic [15:0] obs_q [$];

   always @(negedge clk) begin
      if (!rst_seen) begin
         in_win    = 1'b0;
         win_idx   = 0;
         gap_cnt   = 0;
         have_done = 1'b0;
         MISO      = 1'b0;
         obs_q.delete();
      end else begin
         if (ss_prev && !SS_n) begin
            in_win    = 1'b1;
            rises     = 0;
            mosi_word = '0;
            if (win_idx % 2 == 0) begin
               cmd_start_cyc = cyc;
               chk("start_on_timer_all_ones", 32'((cyc - 1 - rst_cyc) % (1 << PW)),
                   32'((1 << PW) - 1));
               if (have_done)
                  chk("start_first_all_ones_after_done",
                      32'((cyc - done_cyc >= 2) && (cyc - done_cyc <= (1 << PW) + 1)), 32'd1);
               tx = 16'hA5C3;
            end else begin
               chk("gap_clks", 32'(gap_cnt), 32'd2);
               tx = adc_word[last_cmd[13:11]];
            end
            MISO = tx[15];
         end else if (!ss_prev && SS_n && in_win) begin
            in_win = 1'b0;
            chk("sclk_rises_per_frame", 32'(rises), 32'd16);
            obs_q.push_back(mosi_word);
            if (win_idx % 2 == 0) last_cmd = mosi_word;
            win_idx++;
            gap_cnt = 1;
         end else if (SS_n) begin
            gap_cnt++;
         end
         if (!SS_n && in_win) begin
            if (!sclk_prev && SCLK) begin
               mosi_word = {mosi_word[14:0], MOSI};
               rises++;
            end
            if (sclk_prev && !SCLK && rises > 0 && rises < 16) MISO = tx[15 - rises];
         end
         if (cnv_cmplt) begin
            chk("cnv_cmplt_one_clk", 32'(cnv_prev), 32'd0);
            done_cyc  = cyc;
            have_done = 1'b1;
         end
      end
      ss_prev   = SS_n;
      sclk_prev = SCLK;
      cnv_prev  = cnv_cmplt;
   end

   // Reference model: conversion n reads channel chmap[n%4] into result n%4.
   int          chmap [4] = '{0, 1, 3, 4};
   logic [11:0] exp_regs [4];
   int          conv_idx = 0;
   int          ref_lat = 0;
   bit          have_lat = 1'b0;

   task automatic clear_model();
      for (int i = 0; i < 4; i++) exp_regs[i] = '0;
      conv_idx = 0;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_ss_n", 32'(SS_n), 32'd1);
      chk("rst_sclk", 32'(SCLK), 32'd1);
      chk("rst_mosi", 32'(MOSI), 32'd0);
      chk("rst_batt", 32'(batt), 32'd0);
      chk("rst_curr", 32'(curr), 32'd0);
      chk("rst_brake", 32'(brake), 32'd0);
      chk("rst_torque", 32'(torque), 32'd0);
      chk("rst_cnv_cmplt", 32'(cnv_cmplt), 32'd0);
      rst_n = 1'b1;
      clear_model();
   endtask

   task automatic wait_conv();
      bit          seen;
      int          pos;
      int          ch;
      int          lat;
      logic [15:0] ecmd;
      logic [15:0] got;
      seen = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         #1;
         if (cnv_cmplt) begin
            seen = 1'b1;
            break;
         end
      end
      chk("cnv_cmplt_within_budget", 32'(seen), 32'd1);
      if (!seen) return;
      pos = conv_idx % 4;
      ch  = chmap[pos];
      exp_regs[pos] = adc_word[ch][11:0];
      conv_idx++;
      chk("batt", 32'(batt), 32'(exp_regs[0]));
      chk("curr", 32'(curr), 32'(exp_regs[1]));
      chk("brake", 32'(brake), 32'(exp_regs[2]));
      chk("torque", 32'(torque), 32'(exp_regs[3]));
      ecmd = {2'b00, 3'(ch), 11'h000};
      chk("frames_per_conversion", 32'(obs_q.size()), 32'd2);
      for (int f = 0; f < 2; f++) begin
         if (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            chk("mosi_command", 32'(got), 32'(ecmd));
         end
      end
      lat = cyc - cmd_start_cyc;
      chk("latency_range", 32'((lat >= 1042) && (lat <= 1062)), 32'd1);
      if (have_lat) begin
         chk("latency_constant", 32'(lat), 32'(ref_lat));
      end else begin
         ref_lat  = lat;
         have_lat = 1'b1;
      end
   endtask

   typedef struct {
      logic [15:0] w0;
      logic [15:0] w1;
      logic [15:0] w3;
      logic [15:0] w4;
      int          n_conv;
      logic [11:0] e_batt;
      logic [11:0] e_curr;
      logic [11:0] e_brake;
      logic [11:0] e_torque;
   } vec_t;

   vec_t vecs [4];

   initial begin
      bit found;

      vecs[0] = '{16'h0A98, 16'h0000, 16'h0000, 16'h0000, 1, 12'hA98, 12'h000, 12'h000, 12'h000};
      vecs[1] = '{16'h0111, 16'h0222, 16'h0333, 16'h0444, 5, 12'h111, 12'h222, 12'h333, 12'h444};
      vecs[2] = '{16'hF7FF, 16'h0000, 16'h0000, 16'h0000, 1, 12'h7FF, 12'h000, 12'h000, 12'h000};
      vecs[3] = '{16'hF123, 16'h8456, 16'h0789, 16'h7ABC, 4, 12'h123, 12'h456, 12'h789, 12'hABC};

      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < 8; c++) adc_word[c] = 16'hFFFF;
         adc_word[0] = vecs[i].w0;
         adc_word[1] = vecs[i].w1;
         adc_word[3] = vecs[i].w3;
         adc_word[4] = vecs[i].w4;
         reset_dut();
         for (int k = 0; k < vecs[i].n_conv; k++) wait_conv();
         chk("tbl_batt", 32'(batt), 32'(vecs[i].e_batt));
         chk("tbl_curr", 32'(curr), 32'(vecs[i].e_curr));
         chk("tbl_brake", 32'(brake), 32'(vecs[i].e_brake));
         chk("tbl_torque", 32'(torque), 32'(vecs[i].e_torque));
      end

      // Reset in the middle of the second conversion's read frame.
      adc_word[0] = 16'h15A5;
      adc_word[1] = 16'h2B6C;
      adc_word[3] = 16'h3ABC;
      adc_word[4] = 16'h4444;
      reset_dut();
      wait_conv();
      found = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         #1;
         if (in_win && (win_idx % 2 == 1) && (rises == 8)) begin
            found = 1'b1;
            break;
         end
      end
      chk("reach_mid_read", 32'(found), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      chk("midrst_ss_n", 32'(SS_n), 32'd1);
      chk("midrst_sclk", 32'(SCLK), 32'd1);
      chk("midrst_curr", 32'(curr), 32'd0);
      chk("midrst_cnv_cmplt", 32'(cnv_cmplt), 32'd0);
      rst_n = 1'b1;
      clear_model();
      wait_conv();

      // Random ADC contents, back-to-back conversions with the short period.
      reset_dut();
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 8; c++) adc_word[c] = 16'($urandom);
         for (int k = 0; k < 4; k++) wait_conv();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
